// File: rtl/product_accumulator.sv
// product_accumulator: sums a stream of unsigned products from the array
// multiplier. A sum closes after N_TERMS products, or earlier on a flush.
// The result is then held on a valid/ready output port until the consumer
// takes it. in_ready and out_valid come straight from the state register,
// so there is no combinational path from any input to any output.
module product_accumulator #(
  parameter int PROD_W  = 8,
  parameter int N_TERMS = 4,
  parameter int ACC_W   = 10,
  parameter int CNT_W   = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_product,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic [CNT_W-1:0]  out_terms
);

  typedef enum logic {
    S_ACCUM  = 1'b0,
    S_OUTPUT = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_TERMS - 1);

  state_t           state;
  state_t           state_next;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             close;
  logic [ACC_W-1:0] sum_with;
  logic [CNT_W-1:0] cnt_with;

  // The handshake outputs are decoded from the state register only.
  assign in_ready  = (state == S_ACCUM);
  assign out_valid = (state == S_OUTPUT);

  // An accept can only happen in ACCUM because in_ready gates it.
  assign accept   = in_valid & in_ready;
  assign sum_with = acc + (accept ? ACC_W'(in_product) : '0);
  assign cnt_with = cnt + (accept ? CNT_W'(1) : '0);

  // Close on the last term, or on a flush that has at least one term to
  // report. A flush on the last accept still closes just once.
  assign close = in_ready &&
                 ((accept && (cnt == LAST_CNT)) ||
                  (flush && ((cnt != '0) || accept)));

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // its inputs from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_ACCUM;
    else        state <= state_next;
  end

  // Next-state logic: ACCUM -> OUTPUT on close, OUTPUT -> ACCUM on out_ready.
  // NOTE: the default assignment first keeps this block latch-free on every
  // path through the case statement.
  always_comb begin
    state_next = state;
    case (state)
      S_ACCUM:  if (close)     state_next = S_OUTPUT;
      S_OUTPUT: if (out_ready) state_next = S_ACCUM;
      default:                 state_next = S_ACCUM;
    endcase
  end

  // Datapath: accumulate on accept, and on close move the sum to the output
  // registers and clear the accumulator in the same edge. The output
  // registers only change on close, so they hold stable throughout OUTPUT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      cnt       <= '0;
      out_sum   <= '0;
      out_terms <= '0;
    end else if (close) begin
      out_sum   <= sum_with;
      out_terms <= cnt_with;
      acc       <= '0;
      cnt       <= '0;
    end else if (accept) begin
      acc <= sum_with;
      cnt <= cnt_with;
    end
  end

endmodule

// File: tb/tb_product_accumulator.sv
// Self-checking bench for product_accumulator. It runs a cycle-by-cycle
// vector table, then hand-written backpressure and reset sequences, then
// random traffic compared against a queue-based model of the sums.
module tb_product_accumulator;

  localparam int PROD_W  = 8;
  localparam int N_TERMS = 4;
  localparam int ACC_W   = 10;
  localparam int CNT_W   = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [PROD_W-1:0] in_product;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_sum;
  logic [CNT_W-1:0]  out_terms;

  int tests = 0;
  int fails = 0;

  product_accumulator #(
    .PROD_W (PROD_W),
    .N_TERMS(N_TERMS),
    .ACC_W  (ACC_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_product(in_product),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_terms (out_terms)
  );

  always #5 clk = ~clk;

  // One vector: inputs driven for a cycle, and the outputs expected during
  // that same cycle (before the edge that consumes the inputs).
  typedef struct packed {
    logic              v;
    logic [PROD_W-1:0] p;
    logic              f;
    logic              r;
    logic              e_ir;
    logic              e_ov;
    logic [ACC_W-1:0]  e_sum;
    logic [CNT_W-1:0]  e_terms;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_outs(input string tag, input logic ir, input logic ov,
                            input int sum, input int terms);
    check({tag, " in_ready"},  int'(in_ready),  int'(ir));
    check({tag, " out_valid"}, int'(out_valid), int'(ov));
    check({tag, " out_sum"},   int'(out_sum),   sum);
    check({tag, " out_terms"}, int'(out_terms), terms);
  endtask

  // Called at a falling edge: drive inputs, then wait to the next falling edge.
  task automatic drive(input logic v, input int p, input logic f, input logic r);
    in_valid   = v;
    in_product = PROD_W'(p);
    flush      = f;
    out_ready  = r;
    @(negedge clk);
  endtask

  task automatic add(input logic v, input int p, input logic f, input logic r,
                     input logic ir, input logic ov, input int sum, input int terms);
    tbl.push_back({v, PROD_W'(p), f, r, ir, ov, ACC_W'(sum), CNT_W'(terms)});
  endtask

  // Random-phase reference: the products of the open sum and the held result.
  int   cur[$];
  bit   m_out;
  int   m_sum;
  int   m_terms;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_product = '0; flush = 1'b0; out_ready = 1'b0;
    #1;
    check("reset out_valid", int'(out_valid), 0);
    check("reset out_sum",   int'(out_sum),   0);
    check("reset out_terms", int'(out_terms), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    //   v  p    f  r   ir ov sum  terms
    // Full sum: 4 x 225, in_ready low for exactly one cycle.
    add(1, 225, 0, 1,  1, 0, 0,   0);
    add(1, 225, 0, 1,  1, 0, 0,   0);
    add(1, 225, 0, 1,  1, 0, 0,   0);
    add(1, 225, 0, 1,  1, 0, 0,   0);
    add(0, 0,   0, 1,  0, 1, 900, 4);
    add(0, 0,   0, 1,  1, 0, 900, 4);
    // Early flush after 7, 8.
    add(1, 7,   0, 1,  1, 0, 900, 4);
    add(1, 8,   0, 1,  1, 0, 900, 4);
    add(0, 0,   1, 1,  1, 0, 900, 4);
    add(0, 0,   0, 1,  0, 1, 15,  2);
    // Flush with empty accumulator is ignored.
    add(0, 0,   1, 1,  1, 0, 15,  2);
    add(0, 0,   0, 1,  1, 0, 15,  2);
    // Flush together with the 4th accept closes once.
    add(1, 10,  0, 1,  1, 0, 15,  2);
    add(1, 20,  0, 1,  1, 0, 15,  2);
    add(1, 30,  0, 1,  1, 0, 15,  2);
    add(1, 40,  1, 1,  1, 0, 15,  2);
    add(0, 0,   1, 1,  0, 1, 100, 4);
    add(0, 0,   0, 1,  1, 0, 100, 4);
    add(0, 0,   0, 1,  1, 0, 100, 4);

    foreach (tbl[i]) begin
      check_outs($sformatf("vec%0d", i), tbl[i].e_ir, tbl[i].e_ov,
                 int'(tbl[i].e_sum), int'(tbl[i].e_terms));
      drive(tbl[i].v, int'(tbl[i].p), tbl[i].f, tbl[i].r);
    end

    // Backpressure: 1..4, then out_ready low for 5 cycles with 9 offered.
    for (int i = 1; i <= 4; i++) drive(1, i, 0, 0);
    for (int i = 0; i < 5; i++) begin
      check_outs($sformatf("bp hold%0d", i), 0, 1, 10, 4);
      drive(1, 9, 0, 0);
    end
    check_outs("bp release", 0, 1, 10, 4);
    drive(1, 9, 0, 1);
    check("bp ready again", int'(in_ready), 1);
    drive(1, 9, 0, 1);
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 1);
    check_outs("bp next sum", 1, 0, 10, 4);
    drive(0, 0, 1, 1);
    check_outs("bp next sum", 0, 1, 9, 1);
    drive(0, 0, 0, 1);

    // Reset mid-sum: 50, 60, then an asynchronous reset pulse.
    drive(1, 50, 0, 1);
    drive(1, 60, 0, 1);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst out_valid", int'(out_valid), 0);
    check("rst out_sum",   int'(out_sum),   0);
    check("rst out_terms", int'(out_terms), 0);
    repeat (2) @(negedge clk);
    check("rst held out_sum", int'(out_sum), 0);
    rst_n = 1'b1;
    check("rst in_ready", int'(in_ready), 1);
    for (int i = 0; i < 4; i++) drive(1, 1, 0, 1);
    check_outs("rst next sum", 0, 1, 4, 4);
    drive(0, 0, 0, 1);

    // Random traffic against a queue model of open and held sums.
    cur.delete();
    m_out = 1'b0; m_sum = 4; m_terms = 4;
    for (int c = 0; c < 3000; c++) begin
      logic v, f, r;
      int   p;
      check_outs("rand", !m_out, m_out, m_sum, m_terms);
      v = ($urandom_range(0, 3) != 0);
      f = ($urandom_range(0, 7) == 0);
      r = ($urandom_range(0, 2) != 0);
      p = $urandom_range(0, 255);
      if (!m_out) begin
        if (v) cur.push_back(p);
        if (cur.size() == N_TERMS || (f && cur.size() > 0)) begin
          m_sum = 0;
          foreach (cur[k]) m_sum += cur[k];
          m_terms = cur.size();
          cur.delete();
          m_out = 1'b1;
        end
      end else if (r) begin
        m_out = 1'b0;
      end
      drive(v, p, f, r);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
